// File: rtl/a_io_l3_in_serialize_a_m_axi_read_beat_tracker_if.sv
// Control-record and AXI R-channel bundle between the burst converter, memory and user side.
// The master drives the in_* signals; the beat tracker (slave) drives the out_* signals.
interface a_io_l3_in_serialize_a_m_axi_read_beat_tracker_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTSTANDING = 16
);
    localparam int CW = $clog2(NUM_OUTSTANDING) + 1;

    logic                  in_CTRL_INFO;
    logic [7:0]            in_CTRL_LEN;
    logic                  in_CTRL_VALID;
    logic                  out_CTRL_READY;
    logic [DATA_WIDTH-1:0] in_RDATA;
    logic                  in_RLAST;
    logic [1:0]            in_RRESP;
    logic                  in_RVALID;
    logic                  out_RREADY;
    logic [DATA_WIDTH-1:0] out_DATA;
    logic                  out_LAST;
    logic                  out_VALID;
    logic                  in_READY;
    logic [1:0]            out_ERR;
    logic [CW-1:0]         out_OST_CNT;

    modport master (
        output in_CTRL_INFO, in_CTRL_LEN, in_CTRL_VALID, in_RDATA, in_RLAST,
               in_RRESP, in_RVALID, in_READY,
        input  out_CTRL_READY, out_RREADY, out_DATA, out_LAST, out_VALID,
               out_ERR, out_OST_CNT
    );

    modport slave (
        input  in_CTRL_INFO, in_CTRL_LEN, in_CTRL_VALID, in_RDATA, in_RLAST,
               in_RRESP, in_RVALID, in_READY,
        output out_CTRL_READY, out_RREADY, out_DATA, out_LAST, out_VALID,
               out_ERR, out_OST_CNT
    );
endinterface

// File: rtl/a_io_l3_in_serialize_a_m_axi_read_beat_tracker.sv
// Queues burst control records, counts returning R beats against the head record,
// forwards data with a user-request LAST flag, and latches sticky length/response errors.
module a_io_l3_in_serialize_a_m_axi_read_beat_tracker #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTSTANDING = 16,
    parameter int RESP_CHECK      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    a_io_l3_in_serialize_a_m_axi_read_beat_tracker_if.slave bus
);
    localparam int PW = $clog2(NUM_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic       info;
        logic [7:0] len;
    } ctrl_t;

    ctrl_t         mem [NUM_OUTSTANDING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ost_cnt;
    logic [7:0]    beat_cnt;
    logic [1:0]    err;

    ctrl_t head;
    logic  empty, full, push, accept, pop, expect_last, mismatch, resp_bad;

    always_comb begin
        head        = mem[rd_ptr];
        empty       = (ost_cnt == '0);
        full        = (ost_cnt == CW'(NUM_OUTSTANDING));
        push        = bus.in_CTRL_VALID & ~full;
        expect_last = (beat_cnt == head.len);
        accept      = bus.in_RVALID & bus.in_READY & ~empty;
        pop         = accept & expect_last;
        // Length mismatch is only flagged; the queued length still decides the pop.
        mismatch    = accept & (bus.in_RLAST != expect_last);
        resp_bad    = accept & (RESP_CHECK != 0) & (bus.in_RRESP != 2'b00);
    end

    assign bus.out_CTRL_READY = ~full;
    assign bus.out_VALID      = bus.in_RVALID & ~empty;
    assign bus.out_RREADY     = bus.in_READY & ~empty;
    assign bus.out_DATA       = bus.in_RDATA;
    assign bus.out_LAST       = expect_last & head.info & bus.in_RVALID & ~empty;
    assign bus.out_ERR        = err;
    assign bus.out_OST_CNT    = ost_cnt;

    // Record storage needs no reset: entries are only read once counted as occupied.
    always_ff @(posedge clk) begin
        if (clk_en && push)
            mem[wr_ptr] <= '{info: bus.in_CTRL_INFO, len: bus.in_CTRL_LEN};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ost_cnt  <= '0;
            beat_cnt <= '0;
            err      <= '0;
        end else if (clk_en) begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   ost_cnt <= ost_cnt + CW'(1);
                2'b01:   ost_cnt <= ost_cnt - CW'(1);
                default: ost_cnt <= ost_cnt;
            endcase
            if (accept)
                beat_cnt <= expect_last ? 8'd0 : beat_cnt + 8'd1;
            err <= err | {resp_bad, mismatch};
        end
    end
endmodule

// File: tb/tb_a_io_l3_in_serialize_a_m_axi_read_beat_tracker.sv
// Directed bench: two trackers (response checking on/off) driven by identical stimulus.
module tb_a_io_l3_in_serialize_a_m_axi_read_beat_tracker;
    logic        clk = 1'b0;
    logic        reset, clk_en;
    logic        ctrl_info, ctrl_valid, rlast, rvalid, rdy;
    logic [7:0]  ctrl_len;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    a_io_l3_in_serialize_a_m_axi_read_beat_tracker_if #(.DATA_WIDTH(32), .NUM_OUTSTANDING(16)) b0 ();
    a_io_l3_in_serialize_a_m_axi_read_beat_tracker_if #(.DATA_WIDTH(32), .NUM_OUTSTANDING(16)) b1 ();

    assign b0.in_CTRL_INFO  = ctrl_info;  assign b1.in_CTRL_INFO  = ctrl_info;
    assign b0.in_CTRL_LEN   = ctrl_len;   assign b1.in_CTRL_LEN   = ctrl_len;
    assign b0.in_CTRL_VALID = ctrl_valid; assign b1.in_CTRL_VALID = ctrl_valid;
    assign b0.in_RDATA      = rdata;      assign b1.in_RDATA      = rdata;
    assign b0.in_RLAST      = rlast;      assign b1.in_RLAST      = rlast;
    assign b0.in_RRESP      = rresp;      assign b1.in_RRESP      = rresp;
    assign b0.in_RVALID     = rvalid;     assign b1.in_RVALID     = rvalid;
    assign b0.in_READY      = rdy;        assign b1.in_READY      = rdy;

    a_io_l3_in_serialize_a_m_axi_read_beat_tracker #(
        .DATA_WIDTH(32), .NUM_OUTSTANDING(16), .RESP_CHECK(1)
    ) dut0 (.clk(clk), .reset(reset), .clk_en(clk_en), .bus(b0));

    a_io_l3_in_serialize_a_m_axi_read_beat_tracker #(
        .DATA_WIDTH(32), .NUM_OUTSTANDING(16), .RESP_CHECK(0)
    ) dut1 (.clk(clk), .reset(reset), .clk_en(clk_en), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] len, input logic info);
        ctrl_len = len; ctrl_info = info; ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic l,
                        input logic [1:0] r, input logic exp_last);
        rdata = d; rlast = l; rresp = r; rvalid = 1'b1;
        #1;
        chk({tag, " data"}, b0.out_DATA, d);
        chk({tag, " last"}, b0.out_LAST, exp_last);
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clk_en = 1'b1; ctrl_info = 0; ctrl_valid = 0; ctrl_len = '0;
        rlast = 0; rvalid = 0; rdy = 1'b1; rdata = '0; rresp = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst ost",   b0.out_OST_CNT, 0);
        chk("rst cready", b0.out_CTRL_READY, 1);
        chk("rst valid", b0.out_VALID, 0);
        chk("rst rready", b0.out_RREADY, 0);
        chk("rst err",   b0.out_ERR, 0);

        // single 4-beat request
        push(8'd3, 1'b1);
        chk("t1 ost", b0.out_OST_CNT, 1);
        for (int i = 0; i < 4; i++)
            beat("t1", 32'h100 + i, i == 3, 2'b00, i == 3);
        chk("t1 ost end", b0.out_OST_CNT, 0);
        chk("t1 rready empty", b0.out_RREADY, 0);
        chk("t1 err", b0.out_ERR, 0);

        // two bursts forming one request
        push(8'd15, 1'b0);
        push(8'd1, 1'b1);
        chk("t2 ost", b0.out_OST_CNT, 2);
        for (int i = 0; i < 18; i++) begin
            beat("t2", 32'h200 + i, (i == 15) || (i == 17), 2'b00, i == 17);
            if (i == 15) chk("t2 ost mid", b0.out_OST_CNT, 1);
        end
        chk("t2 ost end", b0.out_OST_CNT, 0);

        // fill the control FIFO
        push(8'd1, 1'b1);
        for (int i = 1; i < 16; i++) push(8'd0, 1'b0);
        chk("t3 cready full", b0.out_CTRL_READY, 0);
        chk("t3 ost full", b0.out_OST_CNT, 16);
        push(8'd7, 1'b1);
        chk("t3 ost no push", b0.out_OST_CNT, 16);
        beat("t3 b0", 32'h300, 1'b0, 2'b00, 1'b0);
        chk("t3 cready hold", b0.out_CTRL_READY, 0);
        beat("t3 b1", 32'h301, 1'b1, 2'b00, 1'b1);
        chk("t3 cready back", b0.out_CTRL_READY, 1);
        chk("t3 ost pop", b0.out_OST_CNT, 15);
        for (int i = 0; i < 15; i++)
            beat("t3 drain", 32'h310 + i, 1'b1, 2'b00, 1'b0);
        chk("t3 ost end", b0.out_OST_CNT, 0);
        chk("t3 err", b0.out_ERR, 0);

        // early RLAST: flagged, counting continues on queued length
        push(8'd3, 1'b1);
        beat("t4 b0", 32'h400, 1'b0, 2'b00, 1'b0);
        beat("t4 b1", 32'h401, 1'b1, 2'b00, 1'b0);
        chk("t4 err", b0.out_ERR, 2'b01);
        chk("t4 ost held", b0.out_OST_CNT, 1);
        beat("t4 b2", 32'h402, 1'b0, 2'b00, 1'b0);
        chk("t4 ost b2", b0.out_OST_CNT, 1);
        beat("t4 b3", 32'h403, 1'b1, 2'b00, 1'b1);
        chk("t4 ost end", b0.out_OST_CNT, 0);
        chk("t4 err sticky", b0.out_ERR, 2'b01);

        // bad response, with and without checking
        do_reset();
        #1;
        chk("t5 err cleared", b0.out_ERR, 0);
        push(8'd0, 1'b1);
        beat("t5", 32'h500, 1'b1, 2'b10, 1'b1);
        chk("t5 err chk", b0.out_ERR, 2'b10);
        chk("t5 err nochk", b1.out_ERR, 2'b00);

        // ready toggling and clock-enable stall mid-burst
        begin
            int idx = 0;
            push(8'd5, 1'b1);
            for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
                rdy    = (cyc % 2) == 1;
                clk_en = !(cyc >= 4 && cyc <= 6);
                rvalid = 1'b1; rdata = 32'hA0 + idx; rlast = (idx == 5);
                #1;
                chk("t6 rready", b0.out_RREADY, rdy);
                if (rdy && clk_en) begin
                    chk("t6 data", b0.out_DATA, 32'hA0 + idx);
                    chk("t6 last", b0.out_LAST, idx == 5);
                    idx++;
                end else if (!clk_en) begin
                    chk("t6 ost hold", b0.out_OST_CNT, 1);
                end
                tick();
            end
            rvalid = 1'b0; rlast = 1'b0; rdy = 1'b1; clk_en = 1'b1;
            chk("t6 beats", idx, 6);
            chk("t6 ost end", b0.out_OST_CNT, 0);
            chk("t6 ost end nochk", b1.out_OST_CNT, 0);
            chk("t6 err", b0.out_ERR, 2'b10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
